// File: rtl/video_timing_generator.sv
`timescale 1ns/1ps
// video_timing_generator_pkg: standard selector shared by the timing
// generator, the encoder and the testbench.
package video_timing_generator_pkg;
   typedef enum logic [1:0] {
      STD_PAL   = 2'd0,
      STD_NTSC  = 2'd1,
      STD_SECAM = 2'd2
   } video_standard_e;
endpackage

// video_timing_generator: free-running raster timing source for the
// composite video encoder.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   video_standard    requested standard, sampled only at frame start
//   sync              1 = sync tip
//   newline/newframe  1-clk pulses at h=0 / (h=0,v=0)
//   qam_startburst    1-clk pulse at h=BURST_START on burst lines (PAL/NTSC)
//   secam_enabled     level, body lines of a SECAM frame
//   even_field        field parity, toggles with each newframe
//   active            active-video window
//   hpos/vpos         raster position aligned with the other outputs
//   cur_standard      standard latched for the current frame
module video_timing_generator
   import video_timing_generator_pkg::*;
#(
   parameter int unsigned LINE_CLKS_PAL  = 3072,
   parameter int unsigned LINE_CLKS_NTSC = 3051,
   parameter int unsigned HSYNC_CLKS     = 226,
   parameter int unsigned BURST_START    = 269,
   parameter int unsigned VIS_START      = 504,
   parameter int unsigned VIS_END        = 2976,
   parameter int unsigned LINES_PAL      = 312,
   parameter int unsigned LINES_NTSC     = 262,
   parameter int unsigned VBLANK_LINES   = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  video_standard_e video_standard,
   output logic            sync,
   output logic            newline,
   output logic            newframe,
   output logic            qam_startburst,
   output logic            secam_enabled,
   output logic            even_field,
   output logic            active,
   output logic [11:0]     hpos,
   output logic [8:0]      vpos,
   output video_standard_e cur_standard
);

   localparam int unsigned HW = 12;
   localparam int unsigned VW = 9;

   localparam logic [HW-1:0] H_LAST_PAL    = HW'(LINE_CLKS_PAL - 1);
   localparam logic [HW-1:0] H_LAST_NTSC   = HW'(LINE_CLKS_NTSC - 1);
   localparam logic [HW-1:0] HALF_PAL      = HW'(LINE_CLKS_PAL / 2);
   localparam logic [HW-1:0] HALF_NTSC     = HW'(LINE_CLKS_NTSC / 2);
   localparam logic [HW-1:0] BROAD1_PAL    = HW'(LINE_CLKS_PAL / 2 - HSYNC_CLKS);
   localparam logic [HW-1:0] BROAD1_NTSC   = HW'(LINE_CLKS_NTSC / 2 - HSYNC_CLKS);
   localparam logic [HW-1:0] BROAD2_PAL    = HW'(LINE_CLKS_PAL - HSYNC_CLKS);
   localparam logic [HW-1:0] BROAD2_NTSC   = HW'(LINE_CLKS_NTSC - HSYNC_CLKS);
   localparam logic [HW-1:0] HSYNC_W       = HW'(HSYNC_CLKS);
   localparam logic [HW-1:0] EQ_W          = HW'(HSYNC_CLKS / 2);
   localparam logic [HW-1:0] BURST_H       = HW'(BURST_START);
   localparam logic [HW-1:0] VIS_S         = HW'(VIS_START);
   localparam logic [HW-1:0] VIS_E         = HW'(VIS_END);
   localparam logic [VW-1:0] V_LAST_PAL    = VW'(LINES_PAL - 1);
   localparam logic [VW-1:0] V_LAST_NTSC   = VW'(LINES_NTSC - 1);
   localparam logic [VW-1:0] VBLANK_V      = VW'(VBLANK_LINES);
   localparam logic [VW-1:0] V_BROAD_END   = VW'(3);
   localparam logic [VW-1:0] V_EQ_END      = VW'(6);

   // raster state
   logic [HW-1:0]   h_q, h_d;
   logic [VW-1:0]   v_q, v_d;
   video_standard_e std_q, std_d;
   logic            started_q, started_d;
   logic            field_q, field_d;

   // registered outputs
   logic            sync_q, sync_d;
   logic            newline_q, newline_d;
   logic            newframe_q, newframe_d;
   logic            qam_startburst_q, qam_startburst_d;
   logic            secam_enabled_q, secam_enabled_d;
   logic            even_field_q, even_field_d;
   logic            active_q, active_d;
   logic [HW-1:0]   hpos_q, hpos_d;
   logic [VW-1:0]   vpos_q, vpos_d;
   video_standard_e cur_standard_q, cur_standard_d;

   // line/field geometry of the latched standard
   logic [HW-1:0]   h_last, half, broad1_end, broad2_end, eq2_end;
   logic [VW-1:0]   v_last;
   logic            line_end, frame_end, body_line;

   // geometry select; SECAM shares PAL timing
   always_comb begin
      h_last     = H_LAST_PAL;
      half       = HALF_PAL;
      broad1_end = BROAD1_PAL;
      broad2_end = BROAD2_PAL;
      v_last     = V_LAST_PAL;
      if (std_q == STD_NTSC) begin
         h_last     = H_LAST_NTSC;
         half       = HALF_NTSC;
         broad1_end = BROAD1_NTSC;
         broad2_end = BROAD2_NTSC;
         v_last     = V_LAST_NTSC;
      end
      eq2_end = half + EQ_W;
   end

   // counter advance; the first cycle after reset only loads the standard
   always_comb begin
      h_d       = h_q;
      v_d       = v_q;
      std_d     = std_q;
      started_d = 1'b1;
      field_d   = field_q;
      line_end  = (h_q == h_last);
      frame_end = line_end && (v_q == v_last);
      if (!started_q) begin
         std_d = video_standard;
      end else if (line_end) begin
         h_d = '0;
         if (frame_end) begin
            v_d     = '0;
            std_d   = video_standard;
            field_d = ~field_q;
         end else begin
            v_d = v_q + VW'(1);
         end
      end else begin
         h_d = h_q + HW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q       <= '0;
         v_q       <= '0;
         std_q     <= STD_PAL;
         started_q <= 1'b0;
         field_q   <= 1'b0;
      end else begin
         h_q       <= h_d;
         v_q       <= v_d;
         std_q     <= std_d;
         started_q <= started_d;
         field_q   <= field_d;
      end
   end

   // position decode, held at zero until the counters start running
   always_comb begin
      sync_d           = 1'b0;
      newline_d        = 1'b0;
      newframe_d       = 1'b0;
      qam_startburst_d = 1'b0;
      secam_enabled_d  = 1'b0;
      even_field_d     = 1'b0;
      active_d         = 1'b0;
      hpos_d           = '0;
      vpos_d           = '0;
      cur_standard_d   = STD_PAL;
      body_line        = (v_q >= VBLANK_V);
      if (started_q) begin
         if (v_q < V_BROAD_END) begin
            sync_d = (h_q < broad1_end) || ((h_q >= half) && (h_q < broad2_end));
         end else if (v_q < V_EQ_END) begin
            sync_d = (h_q < EQ_W) || ((h_q >= half) && (h_q < eq2_end));
         end else begin
            sync_d = (h_q < HSYNC_W);
         end
         newline_d        = (h_q == '0);
         newframe_d       = (h_q == '0) && (v_q == '0);
         qam_startburst_d = body_line && (h_q == BURST_H) && (std_q != STD_SECAM);
         secam_enabled_d  = body_line && (std_q == STD_SECAM);
         active_d         = body_line && (h_q >= VIS_S) && (h_q < VIS_E);
         even_field_d     = field_q;
         hpos_d           = h_q;
         vpos_d           = v_q;
         cur_standard_d   = std_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q           <= 1'b0;
         newline_q        <= 1'b0;
         newframe_q       <= 1'b0;
         qam_startburst_q <= 1'b0;
         secam_enabled_q  <= 1'b0;
         even_field_q     <= 1'b0;
         active_q         <= 1'b0;
         hpos_q           <= '0;
         vpos_q           <= '0;
         cur_standard_q   <= STD_PAL;
      end else begin
         sync_q           <= sync_d;
         newline_q        <= newline_d;
         newframe_q       <= newframe_d;
         qam_startburst_q <= qam_startburst_d;
         secam_enabled_q  <= secam_enabled_d;
         even_field_q     <= even_field_d;
         active_q         <= active_d;
         hpos_q           <= hpos_d;
         vpos_q           <= vpos_d;
         cur_standard_q   <= cur_standard_d;
      end
   end

   assign sync           = sync_q;
   assign newline        = newline_q;
   assign newframe       = newframe_q;
   assign qam_startburst = qam_startburst_q;
   assign secam_enabled  = secam_enabled_q;
   assign even_field     = even_field_q;
   assign active         = active_q;
   assign hpos           = hpos_q;
   assign vpos           = vpos_q;
   assign cur_standard   = cur_standard_q;

endmodule

// File: tb/tb_video_timing_generator.sv
`timescale 1ns/1ps
// tb_video_timing_generator: one instance with shrunk raster geometry checked
// cycle by cycle against an elapsed-time reference model, plus one instance
// with the production geometry checked at the vertical-sync boundaries.
module tb_video_timing_generator;
   import video_timing_generator_pkg::*;

   // shrunk geometry for the model-checked instance
   localparam int S_LP = 120;
   localparam int S_LN = 110;
   localparam int S_HS = 10;
   localparam int S_BS = 14;
   localparam int S_VS = 20;
   localparam int S_VE = 100;
   localparam int S_NP = 24;
   localparam int S_NN = 20;
   localparam int S_VB = 8;
   localparam int D_LP = 3072;
   localparam int DCAP = 7 * D_LP;

   typedef struct packed {
      logic        sync, newline, newframe, burst, secam, even, active;
      logic [11:0] hpos;
      logic [8:0]  vpos;
      logic [1:0]  std;
   } obs_t;

   typedef struct {
      int   v;
      int   h;
      logic sync;
      logic nl;
      logic act;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic s_rst_n, d_rst_n;
   video_standard_e s_vs, d_vs, s_cur, d_cur;
   logic s_sync, s_newline, s_newframe, s_burst, s_secam, s_even, s_active;
   logic d_sync, d_newline, d_newframe, d_burst, d_secam, d_even, d_active;
   logic [11:0] s_hpos, d_hpos;
   logic [8:0]  s_vpos, d_vpos;
   obs_t s_now, d_now;

   assign s_now = {s_sync, s_newline, s_newframe, s_burst, s_secam, s_even, s_active, s_hpos, s_vpos, s_cur};
   assign d_now = {d_sync, d_newline, d_newframe, d_burst, d_secam, d_even, d_active, d_hpos, d_vpos, d_cur};

   video_timing_generator #(
      .LINE_CLKS_PAL(S_LP), .LINE_CLKS_NTSC(S_LN), .HSYNC_CLKS(S_HS),
      .BURST_START(S_BS), .VIS_START(S_VS), .VIS_END(S_VE),
      .LINES_PAL(S_NP), .LINES_NTSC(S_NN), .VBLANK_LINES(S_VB)
   ) u_small (
      .clk(clk), .rst_n(s_rst_n), .video_standard(s_vs),
      .sync(s_sync), .newline(s_newline), .newframe(s_newframe),
      .qam_startburst(s_burst), .secam_enabled(s_secam), .even_field(s_even),
      .active(s_active), .hpos(s_hpos), .vpos(s_vpos), .cur_standard(s_cur)
   );

   video_timing_generator u_full (
      .clk(clk), .rst_n(d_rst_n), .video_standard(d_vs),
      .sync(d_sync), .newline(d_newline), .newframe(d_newframe),
      .qam_startburst(d_burst), .secam_enabled(d_secam), .even_field(d_even),
      .active(d_active), .hpos(d_hpos), .vpos(d_vpos), .cur_standard(d_cur)
   );

   int errors = 0;
   int checks = 0;
   int tgt_v  = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return s_newline;
         1:       return s_newframe;
         2:       return d_newline;
         3:       return d_newframe;
         default: return s_newline && (s_vpos == 9'(tgt_v));
      endcase
   endfunction

   // wait (bounded) for a pulse; n = negedges elapsed
   task automatic wait_sig(input int which, input int limit, input string name, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sig(which) && n < limit);
      if (!sig(which)) begin
         checks++;
         errors++;
         $display("FAIL %s: no pulse within %0d cycles", name, n);
      end
   endtask

   // ---------------- reference model (elapsed-time arithmetic) ----------------
   function automatic int line_len(input video_standard_e s);
      return (s == STD_NTSC) ? S_LN : S_LP;
   endfunction

   function automatic int field_lines(input video_standard_e s);
      return (s == STD_NTSC) ? S_NN : S_NP;
   endfunction

   function automatic obs_t ref_out(input int h, input int v, input video_standard_e s, input bit par);
      obs_t o;
      int   l, h2;
      o  = '0;
      l  = line_len(s);
      h2 = l / 2;
      if (v < 3)      o.sync = (h < h2 - S_HS) || (h >= h2 && h < l - S_HS);
      else if (v < 6) o.sync = (h < S_HS / 2) || (h >= h2 && h < h2 + S_HS / 2);
      else            o.sync = (h < S_HS);
      o.newline  = (h == 0);
      o.newframe = (h == 0) && (v == 0);
      o.burst    = (v >= S_VB) && (h == S_BS) && (s != STD_SECAM);
      o.secam    = (v >= S_VB) && (s == STD_SECAM);
      o.active   = (v >= S_VB) && (h >= S_VS) && (h < S_VE);
      o.even     = par;
      o.hpos     = 12'(h);
      o.vpos     = 9'(v);
      o.std      = s;
      return o;
   endfunction

   int              m_n = 0;
   bit              m_valid = 1'b0;
   int              m_t, m_fstart, m_h, m_v;
   video_standard_e m_pend = STD_PAL;
   video_standard_e m_fstd = STD_PAL;
   bit              m_par = 1'b0;

   // m_n counts edges since release: edge 1 latches, edge 2 shows t=0
   initial begin : model
      forever begin
         @(posedge clk or negedge s_rst_n);
         if (!s_rst_n) begin
            m_n     = 0;
            m_valid = 1'b0;
         end else begin
            m_n++;
            if (m_n >= 2) begin
               m_t = m_n - 2;
               if (m_n == 2) begin
                  m_fstart = 0;
                  m_fstd   = m_pend;
                  m_par    = 1'b0;
               end else if (m_t - m_fstart == line_len(m_fstd) * field_lines(m_fstd)) begin
                  m_fstart = m_t;
                  m_fstd   = m_pend;
                  m_par    = ~m_par;
               end
               m_h     = (m_t - m_fstart) % line_len(m_fstd);
               m_v     = (m_t - m_fstart) / line_len(m_fstd);
               m_valid = 1'b1;
            end
            m_pend = s_vs;
         end
      end
   end

   initial begin : scoreboard
      obs_t exp;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            exp = (!s_rst_n || !m_valid) ? obs_t'('0) : ref_out(m_h, m_v, m_fstd, m_par);
            check("s_model", 64'(s_now), 64'(exp));
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin : main
      int   n, nl, bursts, sec, bad, first;
      logic [2:0] d_cap [0:DCAP-1];
      int   d_pos_err;
      vec_t tab[$];

      tab.push_back('{0, 0,    1'b1, 1'b1, 1'b0});
      tab.push_back('{0, 3071, 1'b0, 1'b0, 1'b0});
      tab.push_back('{1, 0,    1'b1, 1'b1, 1'b0});
      tab.push_back('{1, 1309, 1'b1, 1'b0, 1'b0});
      tab.push_back('{1, 1310, 1'b0, 1'b0, 1'b0});
      tab.push_back('{1, 1535, 1'b0, 1'b0, 1'b0});
      tab.push_back('{1, 1536, 1'b1, 1'b0, 1'b0});
      tab.push_back('{1, 2845, 1'b1, 1'b0, 1'b0});
      tab.push_back('{1, 2846, 1'b0, 1'b0, 1'b0});
      tab.push_back('{2, 2845, 1'b1, 1'b0, 1'b0});
      tab.push_back('{3, 0,    1'b1, 1'b1, 1'b0});
      tab.push_back('{4, 112,  1'b1, 1'b0, 1'b0});
      tab.push_back('{4, 113,  1'b0, 1'b0, 1'b0});
      tab.push_back('{4, 1535, 1'b0, 1'b0, 1'b0});
      tab.push_back('{4, 1536, 1'b1, 1'b0, 1'b0});
      tab.push_back('{4, 1648, 1'b1, 1'b0, 1'b0});
      tab.push_back('{4, 1649, 1'b0, 1'b0, 1'b0});
      tab.push_back('{5, 600,  1'b0, 1'b0, 1'b0});
      tab.push_back('{6, 225,  1'b1, 1'b0, 1'b0});
      tab.push_back('{6, 226,  1'b0, 1'b0, 1'b0});

      s_rst_n = 1'b0;
      d_rst_n = 1'b0;
      s_vs    = STD_PAL;
      d_vs    = STD_PAL;
      repeat (3) @(negedge clk);
      check("s_reset", 64'(s_now), 64'(0));
      check("d_reset", 64'(d_now), 64'(0));
      chk_en = 1'b1;

      // release with PAL: one hold cycle, then the (0,0) decode
      #2 s_rst_n = 1'b1;
      @(negedge clk);
      check("s_hold", 64'(s_now), 64'(0));
      @(negedge clk);
      check("s_first", 64'({s_newframe, s_newline, s_sync, s_even, s_hpos, s_vpos}),
            64'({1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 9'd0}));
      wait_sig(0, 400, "s_nl", n);
      check("s_line_pal", 64'(n), 64'(S_LP));

      // mid-frame PAL->NTSC switch waits for the next frame
      tgt_v = 10;
      wait_sig(4, 4000, "s_v10", n);
      s_vs = STD_NTSC;
      wait_sig(0, 400, "s_nl_keep", n);
      check("s_line_keep", 64'(n), 64'(S_LP));
      wait_sig(1, 4000, "s_nf2", n);
      check("s_cur_ntsc", 64'({s_cur, s_even}), 64'({STD_NTSC, 1'b1}));

      // NTSC frame statistics; request SECAM for the following frame
      n = 0; nl = 0; bursts = 0; bad = 0; first = 0;
      s_vs = STD_SECAM;
      do begin
         @(negedge clk);
         n++;
         if (s_newline) begin
            nl++;
            if (first == 0) first = n;
         end
         if (s_burst) begin
            bursts++;
            if (s_hpos != 12'(S_BS) || s_vpos < 9'(S_VB)) bad++;
         end
      end while (!s_newframe && n < 5000);
      check("s_ntsc_frame_len", 64'(n), 64'(S_LN * S_NN));
      check("s_ntsc_line", 64'(first), 64'(S_LN));
      check("s_ntsc_lines", 64'(nl), 64'(S_NN));
      check("s_ntsc_bursts", 64'(bursts), 64'(S_NN - S_VB));
      check("s_ntsc_burst_pos", 64'(bad), 64'(0));
      check("s_cur_secam", 64'({s_cur, s_even}), 64'({STD_SECAM, 1'b0}));

      // SECAM frame: no burst, secam_enabled on body lines only
      n = 0; nl = 0; bursts = 0; sec = 0; bad = 0; first = 0;
      s_vs = STD_PAL;
      do begin
         @(negedge clk);
         n++;
         if (s_newline) begin
            nl++;
            if (first == 0) first = n;
         end
         if (s_burst) bursts++;
         if (s_secam) begin
            sec++;
            if (s_vpos < 9'(S_VB)) bad++;
         end
      end while (!s_newframe && n < 5000);
      check("s_secam_frame_len", 64'(n), 64'(S_LP * S_NP));
      check("s_secam_line", 64'(first), 64'(S_LP));
      check("s_secam_lines", 64'(nl), 64'(S_NP));
      check("s_secam_bursts", 64'(bursts), 64'(0));
      check("s_secam_level", 64'(sec), 64'((S_NP - S_VB) * S_LP));
      check("s_secam_blank", 64'(bad), 64'(0));
      check("s_cur_pal", 64'(s_cur), 64'(STD_PAL));

      // reset pulse mid-frame: asynchronous clear, clean restart
      tgt_v = 15;
      wait_sig(4, 4000, "s_v15", n);
      @(posedge clk);
      #2 s_rst_n = 1'b0;
      #1 check("s_async_rst", 64'(s_now), 64'(0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 s_rst_n = 1'b1;
      @(negedge clk);
      check("s_rst_hold", 64'(s_now), 64'(0));
      @(negedge clk);
      check("s_restart", 64'({s_newframe, s_newline, s_even, s_hpos, s_vpos}),
            64'({1'b1, 1'b1, 1'b0, 12'd0, 9'd0}));

      // random standard changes and reset pulses, model-checked every cycle
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if ($urandom_range(299) == 0) s_vs = video_standard_e'(2'($urandom_range(2)));
         if ($urandom_range(4999) == 0) begin
            #2 s_rst_n = 1'b0;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            #2 s_rst_n = 1'b1;
         end
      end

      // production geometry, PAL: capture the first seven lines
      @(negedge clk);
      #2 d_rst_n = 1'b1;
      @(negedge clk);
      check("d_hold", 64'(d_now), 64'(0));
      @(negedge clk);
      check("d_first", 64'({d_newframe, d_newline, d_hpos, d_vpos}), 64'({1'b1, 1'b1, 12'd0, 9'd0}));
      d_pos_err = 0;
      for (int t = 0; t < DCAP; t++) begin
         if (t > 0) @(negedge clk);
         d_cap[t] = {d_sync, d_newline, d_active};
         if (d_hpos != 12'(t % D_LP) || d_vpos != 9'(t / D_LP)) d_pos_err++;
      end
      check("d_pos", 64'(d_pos_err), 64'(0));
      foreach (tab[i]) begin
         check($sformatf("d_tab%0d_v%0d_h%0d", i, tab[i].v, tab[i].h),
               64'(d_cap[tab[i].v * D_LP + tab[i].h]),
               64'({tab[i].sync, tab[i].nl, tab[i].act}));
      end

      // production geometry, NTSC line length
      @(negedge clk);
      #2 d_rst_n = 1'b0;
      d_vs = STD_NTSC;
      @(negedge clk);
      #2 d_rst_n = 1'b1;
      wait_sig(3, 8, "d_nf", n);
      check("d_ntsc_start", 64'(n), 64'(2));
      check("d_cur_ntsc", 64'(d_cur), 64'(STD_NTSC));
      wait_sig(2, 4000, "d_nl", n);
      check("d_line_ntsc", 64'(n), 64'(3051));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
